// File: rtl/div_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module      : div_sequencer_pkg
// Description : Shared types and constants for the divider sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package div_sequencer_pkg;

    typedef logic [31:0] regval_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam regval_t DIV_MIN_INT  = 32'h8000_0000;
    localparam regval_t DIV_ALL_ONES = 32'hFFFF_FFFF;

    // INT_MIN / -1 is the one signed quotient that does not fit in 32 bits.
    function automatic logic is_signed_overflow(input logic is_signed,
                                                input regval_t numer,
                                                input regval_t denom);
        return is_signed && (numer == DIV_MIN_INT) && (denom == DIV_ALL_ONES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_result_cache.sv
//------------------------------------------------------------------------------
// Module      : div_result_cache
// Description : Single-entry cache of the last completed divide, keyed on
//               {is_signed, numer, denom}. Used under DIV_RESULT_CACHE_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_result_cache
    import div_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fill_en,
    input  logic        fill_is_signed,
    input  logic [31:0] fill_numer,
    input  logic [31:0] fill_denom,
    input  logic [31:0] fill_quotient,
    input  logic [31:0] fill_remainder,
    input  logic        lookup_is_signed,
    input  logic [31:0] lookup_numer,
    input  logic [31:0] lookup_denom,
    output logic        hit,
    output logic [31:0] hit_quotient,
    output logic [31:0] hit_remainder
);

    logic    r_valid;
    logic    r_is_signed;
    regval_t r_numer;
    regval_t r_denom;
    regval_t r_quotient;
    regval_t r_remainder;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid     <= 1'b0;
            r_is_signed <= 1'b0;
            r_numer     <= '0;
            r_denom     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (fill_en) begin
            r_valid     <= 1'b1;
            r_is_signed <= fill_is_signed;
            r_numer     <= fill_numer;
            r_denom     <= fill_denom;
            r_quotient  <= fill_quotient;
            r_remainder <= fill_remainder;
        end
    end

    assign hit = r_valid
              && (r_is_signed == lookup_is_signed)
              && (r_numer == lookup_numer)
              && (r_denom == lookup_denom);
    assign hit_quotient  = r_quotient;
    assign hit_remainder = r_remainder;

endmodule

`default_nettype wire

// File: rtl/div_sequencer.sv
//------------------------------------------------------------------------------
// Module      : div_sequencer
// Description : Ready/valid sequencer for the shared pipelined div/udiv units.
//               Optional result cache enabled by macro DIV_RESULT_CACHE_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        req_valid,
    input  logic        req_is_signed,
    input  logic [31:0] req_numer,
    input  logic [31:0] req_denom,
    output logic        req_ready,
    output logic [31:0] div_numer,
    output logic [31:0] div_denom,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remain,
    input  logic [31:0] udiv_quotient,
    input  logic [31:0] udiv_remain,
    input  logic        out_hold,
    output logic        result_valid,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        has_overflow
);

    localparam int              CNT_W      = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic             r_is_signed;
    regval_t          r_numer;
    regval_t          r_denom;
    regval_t          r_quotient;
    regval_t          r_remainder;
    logic             r_valid;
    logic             r_overflow;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_sgn_ovf;
    logic             w_cache_hit;
    logic             w_short;
    logic             w_wait_done;
    regval_t          w_cap_quotient;
    regval_t          w_cap_remainder;
    regval_t          w_cache_quotient;
    regval_t          w_cache_remainder;

    assign w_accept    = req_valid && req_ready;
    assign w_div_zero  = (req_denom == '0);
    assign w_sgn_ovf   = is_signed_overflow(req_is_signed, req_numer, req_denom);
    assign w_short     = w_div_zero || w_sgn_ovf || w_cache_hit;
    assign w_wait_done = (r_state == WAIT) && (r_count == '0);

    assign w_cap_quotient  = r_is_signed ? div_quotient : udiv_quotient;
    assign w_cap_remainder = r_is_signed ? div_remain   : udiv_remain;

`ifdef DIV_RESULT_CACHE_EN
    div_result_cache u_cache (
        .clock            (clock),
        .reset_n          (reset_n),
        .fill_en          (w_wait_done && !flush),
        .fill_is_signed   (r_is_signed),
        .fill_numer       (r_numer),
        .fill_denom       (r_denom),
        .fill_quotient    (w_cap_quotient),
        .fill_remainder   (w_cap_remainder),
        .lookup_is_signed (req_is_signed),
        .lookup_numer     (req_numer),
        .lookup_denom     (req_denom),
        .hit              (w_cache_hit),
        .hit_quotient     (w_cache_quotient),
        .hit_remainder    (w_cache_remainder)
    );
`else
    assign w_cache_hit       = 1'b0;
    assign w_cache_quotient  = '0;
    assign w_cache_remainder = '0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush overrides everything, including a same-cycle request.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        w_state_nxt = w_short ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (r_count == '0) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE: begin
                    req_ready = !out_hold;
                    if (!out_hold) begin
                        if (req_valid) begin
                            w_state_nxt = w_short ? DONE : WAIT;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_is_signed <= 1'b0;
            r_numer     <= '0;
            r_denom     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_numer     <= req_numer;
            r_denom     <= req_denom;
            r_is_signed <= req_is_signed;
            r_count     <= c_cnt_load;
            if (w_div_zero) begin
                r_quotient  <= DIV_ALL_ONES;
                r_remainder <= req_numer;
                r_overflow  <= 1'b1;
                r_valid     <= 1'b1;
            end else if (w_sgn_ovf) begin
                r_quotient  <= DIV_MIN_INT;
                r_remainder <= '0;
                r_overflow  <= 1'b0;
                r_valid     <= 1'b1;
            end else if (w_cache_hit) begin
                r_quotient  <= w_cache_quotient;
                r_remainder <= w_cache_remainder;
                r_overflow  <= 1'b0;
                r_valid     <= 1'b1;
            end else begin
                r_overflow  <= 1'b0;
                r_valid     <= 1'b0;
            end
        end else if (w_wait_done) begin
            r_quotient  <= w_cap_quotient;
            r_remainder <= w_cap_remainder;
            r_overflow  <= 1'b0;
            r_valid     <= 1'b1;
        end else if (r_state == WAIT) begin
            r_count <= r_count - CNT_W'(1);
        end else if ((r_state == DONE) && !out_hold) begin
            r_valid <= 1'b0;
        end
    end

    assign div_numer    = r_numer;
    assign div_denom    = r_denom;
    assign result_valid = r_valid;
    assign quotient     = r_quotient;
    assign remainder    = r_remainder;
    assign has_overflow = r_overflow;

endmodule

`default_nettype wire
